dcache: RTL and testbench

Direct-mapped, byte-granular data cache serving the memory stage.
- Lookup: combinational on a 32-bit read address; returns hit plus one aligned 32-bit word.
- Update: absorbs the byte-serial store stream the memory stage emits, one byte per cycle while write_bit is high.
- Main memory is always written by the memory stage directly, so the cache is write-through by construction and never needs a writeback.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_if.sv | 51 +++++
 rtl/dcache_line_ram.sv | 64 ++++++
 rtl/dcache.sv | 165 ++++++++++++++++
 tb/tb_dcache.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped byte-granular data cache:
//   - default line-index width and byte-offset width
//   - bus widths (CacheDataBus = one aligned word, CacheOneDataBus = one byte)
//   - FSM state encoding (SWEEP / IDLE)
//   - valid-bit operations understood by the line RAM write port
//   - helper that turns a byte offset into a one-hot byte enable
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int INDEX_W_DEF  = 7;
  localparam int OFF_W        = 2;
  localparam int CACHE_DATA_W = 32;  // CacheDataBus
  localparam int CACHE_BYTE_W = 8;   // CacheOneDataBus

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BV_CLEAR  = 2'd0,  // invalidate the whole line
    BV_SET    = 2'd1,  // tag hit: OR the byte enable into bv
    BV_ONEHOT = 2'd2   // tag miss: retag, bv becomes the byte enable
  } bv_op_e;

  function automatic logic [3:0] off_onehot(input logic [OFF_W-1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// -----------------------------------------------------------------------------
// dcache_if
// Bus between the memory stage (master) and the data cache (slave).
//   read_addr    : lookup byte address           (master -> cache)
//   cache_hit    : combinational lookup hit      (cache -> master)
//   cache_data   : hit word, 0 on miss           (cache -> master)
//   write_bit    : store byte valid this cycle   (master -> cache)
//   write_addr   : store byte address            (master -> cache)
//   write_data   : store byte                    (master -> cache)
//   flush_i      : one-cycle invalidate-all      (master -> cache)
//   flush_busy_o : invalidate sweep in progress  (cache -> master)
// Optional feature macro LOAD_FILL_EN adds the load-fill snoop signals
//   fill_valid_i / fill_addr_i / fill_data_i     (master -> cache)
// -----------------------------------------------------------------------------
interface dcache_if;
  import dcache_pkg::*;

  logic [31:0]             read_addr;
  logic                    cache_hit;
  logic [CACHE_DATA_W-1:0] cache_data;
  logic                    write_bit;
  logic [31:0]             write_addr;
  logic [CACHE_BYTE_W-1:0] write_data;
  logic                    flush_i;
  logic                    flush_busy_o;
`ifdef LOAD_FILL_EN
  logic                    fill_valid_i;
  logic [31:0]             fill_addr_i;
  logic [CACHE_BYTE_W-1:0] fill_data_i;

  modport slave (
    input  read_addr, write_bit, write_addr, write_data, flush_i,
           fill_valid_i, fill_addr_i, fill_data_i,
    output cache_hit, cache_data, flush_busy_o
  );
  modport master (
    output read_addr, write_bit, write_addr, write_data, flush_i,
           fill_valid_i, fill_addr_i, fill_data_i,
    input  cache_hit, cache_data, flush_busy_o
  );
`else
  modport slave (
    input  read_addr, write_bit, write_addr, write_data, flush_i,
    output cache_hit, cache_data, flush_busy_o
  );
  modport master (
    output read_addr, write_bit, write_addr, write_data, flush_i,
    input  cache_hit, cache_data, flush_busy_o
  );
`endif
endinterface

// File: rtl/dcache_line_ram.sv
// -----------------------------------------------------------------------------
// dcache_line_ram
// Tag / per-byte-valid / data storage for 2^INDEX_W lines of 4 bytes.
//   clk       : clock
//   rd_idx_i  : combinational read port index
//   rd_tag_o, rd_bv_o, rd_data_o : line contents at rd_idx_i
//   we_i      : write port enable
//   wr_idx_i  : write port index
//   wr_op_i   : valid-bit operation (clear / set / onehot)
//   wr_be_i   : byte enable for the data write
//   wr_tag_i  : tag installed by BV_ONEHOT
//   wr_byte_i : byte written to every enabled lane
//   wr_tag_o  : stored tag at wr_idx_i, lets the owner pick set vs onehot
// Storage carries no reset; the owner's invalidate sweep clears bv.
// -----------------------------------------------------------------------------
module dcache_line_ram
  import dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic                    clk,
  input  logic [INDEX_W-1:0]      rd_idx_i,
  output logic [TAG_W-1:0]        rd_tag_o,
  output logic [3:0]              rd_bv_o,
  output logic [CACHE_DATA_W-1:0] rd_data_o,
  input  logic                    we_i,
  input  logic [INDEX_W-1:0]      wr_idx_i,
  input  bv_op_e                  wr_op_i,
  input  logic [3:0]              wr_be_i,
  input  logic [TAG_W-1:0]        wr_tag_i,
  input  logic [CACHE_BYTE_W-1:0] wr_byte_i,
  output logic [TAG_W-1:0]        wr_tag_o
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [3:0]              bv_q   [LINES];
  logic [CACHE_DATA_W-1:0] data_q [LINES];

  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_bv_o   = bv_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];
  assign wr_tag_o  = tag_q[wr_idx_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      case (wr_op_i)
        BV_CLEAR:  bv_q[wr_idx_i] <= 4'b0000;
        BV_SET:    bv_q[wr_idx_i] <= bv_q[wr_idx_i] | wr_be_i;
        BV_ONEHOT: begin
          bv_q[wr_idx_i]  <= wr_be_i;
          tag_q[wr_idx_i] <= wr_tag_i;
        end
        default:   bv_q[wr_idx_i] <= bv_q[wr_idx_i];
      endcase
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_q[wr_idx_i][8*b +: 8] <= wr_byte_i;
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
// Direct-mapped, byte-granular, write-through data cache for the memory stage.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : dcache_if.slave (lookup, byte-serial store stream, flush)
// Lookups are combinational and only hit on aligned, fully valid lines.
// Store bytes are captured into a one-entry pending register and committed
// to the line RAM on the following cycle.
// Optional feature macro LOAD_FILL_EN: bytes returned by memory on load
// misses are snooped through the same pending/commit path; a store in the
// same cycle takes priority.
// -----------------------------------------------------------------------------
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  dcache_if.slave bus
);

  localparam int TAG_W = 30 - INDEX_W;

  state_e                  state_q;
  logic [INDEX_W-1:0]      sweep_cnt_q;
  logic                    busy_q;

  logic                    pend_v_q, pend_v_d;
  logic [31:0]             pend_addr_q;
  logic [CACHE_BYTE_W-1:0] pend_byte_q;

  logic                    in_v;
  logic [31:0]             in_addr;
  logic [CACHE_BYTE_W-1:0] in_byte;

  // Store stream, optionally merged with load fills (store has priority).
  always_comb begin
    in_v    = bus.write_bit;
    in_addr = bus.write_addr;
    in_byte = bus.write_data;
`ifdef LOAD_FILL_EN
    if (!bus.write_bit && bus.fill_valid_i) begin
      in_v    = 1'b1;
      in_addr = bus.fill_addr_i;
      in_byte = bus.fill_data_i;
    end
`endif
  end

  // Bytes arriving during a sweep or alongside a flush are dropped.
  assign pend_v_d = (state_q == IDLE) && !bus.flush_i && in_v;

  // FSM, sweep counter and pending-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      busy_q      <= 1'b1;
      pend_v_q    <= 1'b0;
    end else begin
      pend_v_q <= pend_v_d;
      case (state_q)
        SWEEP: begin
          if (bus.flush_i) begin
            sweep_cnt_q <= '0;
          end else if (sweep_cnt_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + INDEX_W'(1);
          end
        end
        IDLE: begin
          if (bus.flush_i) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        default: state_q <= SWEEP;
      endcase
    end
  end

  // Pending byte payload: data only, qualified by pend_v_q.
  always_ff @(posedge clk) begin
    if (pend_v_d) begin
      pend_addr_q <= in_addr;
      pend_byte_q <= in_byte;
    end
  end

  logic [INDEX_W-1:0]      pend_idx;
  logic [TAG_W-1:0]        pend_tag;
  logic [OFF_W-1:0]        pend_off;
  logic [INDEX_W-1:0]      rd_idx;
  logic [TAG_W-1:0]        rd_tag_req;

  assign pend_idx   = pend_addr_q[INDEX_W+1:2];
  assign pend_tag   = pend_addr_q[31:INDEX_W+2];
  assign pend_off   = pend_addr_q[OFF_W-1:0];
  assign rd_idx     = bus.read_addr[INDEX_W+1:2];
  assign rd_tag_req = bus.read_addr[31:INDEX_W+2];

  logic                    ram_we;
  logic [INDEX_W-1:0]      ram_wr_idx;
  bv_op_e                  ram_wr_op;
  logic [3:0]              ram_wr_be;
  logic [TAG_W-1:0]        ram_wr_tag_cur;
  logic [TAG_W-1:0]        ram_rd_tag;
  logic [3:0]              ram_rd_bv;
  logic [CACHE_DATA_W-1:0] ram_rd_data;

  // A commit can never coincide with a sweep: pend_v_q is only set from
  // IDLE without flush, so the sweep owns the write port whenever active.
  always_comb begin
    ram_we     = 1'b0;
    ram_wr_idx = pend_idx;
    ram_wr_op  = BV_SET;
    ram_wr_be  = 4'b0000;
    if (state_q == SWEEP) begin
      ram_we     = 1'b1;
      ram_wr_idx = sweep_cnt_q;
      ram_wr_op  = BV_CLEAR;
    end else if (pend_v_q) begin
      ram_we    = 1'b1;
      ram_wr_be = off_onehot(pend_off);
      ram_wr_op = (ram_wr_tag_cur == pend_tag) ? BV_SET : BV_ONEHOT;
    end
  end

  dcache_line_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_ram (
    .clk       (clk),
    .rd_idx_i  (rd_idx),
    .rd_tag_o  (ram_rd_tag),
    .rd_bv_o   (ram_rd_bv),
    .rd_data_o (ram_rd_data),
    .we_i      (ram_we),
    .wr_idx_i  (ram_wr_idx),
    .wr_op_i   (ram_wr_op),
    .wr_be_i   (ram_wr_be),
    .wr_tag_i  (pend_tag),
    .wr_byte_i (pend_byte_q),
    .wr_tag_o  (ram_wr_tag_cur)
  );

  // Conservative RAW guard: any outstanding commit to the looked-up line
  // forces a miss rather than forwarding the pending byte.
  logic hit;
  assign hit = (state_q == IDLE)
            && (bus.read_addr[OFF_W-1:0] == '0)
            && (ram_rd_tag == rd_tag_req)
            && (ram_rd_bv == 4'b1111)
            && !(pend_v_q && (pend_idx == rd_idx));

  assign bus.cache_hit    = hit;
  assign bus.cache_data   = hit ? ram_rd_data : '0;
  assign bus.flush_busy_o = busy_q;

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_if bus();

  dcache #(.INDEX_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  logic lk;
  int   checks   = 0;
  int   failures = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every flagged lookup cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (lk) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got lookup %h expected none", bus.read_addr);
      end else begin
        e = expq.pop_front();
        check1($sformatf("hit@%h", e.addr), {31'b0, bus.cache_hit}, {31'b0, e.hit});
        check1($sformatf("data@%h", e.addr), bus.cache_data, e.data);
      end
    end
  end

  task automatic cyc(input logic wb, input logic [31:0] wa, input logic [7:0] wd,
                     input logic fl, input logic dolk, input logic [31:0] ra,
                     input logic eh, input logic [31:0] ed);
    bus.write_bit  = wb;
    bus.write_addr = wa;
    bus.write_data = wd;
    bus.flush_i    = fl;
    bus.read_addr  = ra;
    lk             = dolk;
    if (dolk) expq.push_back('{addr: ra, hit: eh, data: ed});
    @(posedge clk);
    #1;
    bus.write_bit = 1'b0;
    bus.flush_i   = 1'b0;
    lk            = 1'b0;
`ifdef LOAD_FILL_EN
    bus.fill_valid_i = 1'b0;
`endif
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic h, input logic [31:0] d);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, a, h, d);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

`ifdef LOAD_FILL_EN
  task automatic fill(input logic [31:0] a, input logic [7:0] d);
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = a;
    bus.fill_data_i  = d;
    idle();
  endtask
`endif

  int   n;
  logic hit_seen;

  initial begin
    bus.read_addr  = 32'h0;
    bus.write_bit  = 1'b0;
    bus.write_addr = 32'h0;
    bus.write_data = 8'h0;
    bus.flush_i    = 1'b0;
`ifdef LOAD_FILL_EN
    bus.fill_valid_i = 1'b0;
    bus.fill_addr_i  = 32'h0;
    bus.fill_data_i  = 8'h0;
`endif
    lk  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("busy_in_reset", {31'b0, bus.flush_busy_o}, 32'd1);
    rd(32'h100, 1'b0, 32'h0);
    rd(32'h100, 1'b0, 32'h0);
    rst = 1'b0;

    // Initial sweep: busy for exactly 128 cycles, never a hit.
    n = 0;
    hit_seen = 1'b0;
    bus.read_addr = 32'h100;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.cache_hit) hit_seen = 1'b1;
      if (!bus.flush_busy_o) break;
      n++;
    end
    check1("reset_sweep_cycles", n, 32'd128);
    check1("hit_during_sweep", {31'b0, hit_seen}, 32'd0);
    @(posedge clk);
    #1;
    check1("busy_idle", {31'b0, bus.flush_busy_o}, 32'd0);
    rd(32'h100, 1'b0, 32'h0);

    // Fill one line byte-serially.
    wr(32'h100, 8'h78);
    wr(32'h101, 8'h56);
    wr(32'h102, 8'h34);
    wr(32'h103, 8'h12);
    rd(32'h100, 1'b0, 32'h0);          // last byte still pending
    rd(32'h100, 1'b1, 32'h12345678);
    rd(32'h101, 1'b0, 32'h0);          // unaligned

    // Same index, new tag: reallocates with a single valid byte.
    wr(32'h300, 8'hAA);
    idle();
    rd(32'h100, 1'b0, 32'h0);
    rd(32'h300, 1'b0, 32'h0);
    wr(32'h301, 8'hBB);
    wr(32'h302, 8'hCC);
    wr(32'h303, 8'hDD);
    idle();
    rd(32'h300, 1'b1, 32'hDDCCBBAA);

    // Commit to a neighbouring line does not disturb this lookup.
    cyc(1'b1, 32'h104, 8'h99, 1'b0, 1'b1, 32'h300, 1'b1, 32'hDDCCBBAA);
    rd(32'h300, 1'b1, 32'hDDCCBBAA);

    // RAW guard and idempotent repeated writes.
    wr(32'h200, 8'h11);
    wr(32'h201, 8'h22);
    wr(32'h202, 8'h33);
    wr(32'h203, 8'h44);
    idle();
    rd(32'h200, 1'b1, 32'h44332211);
    wr(32'h200, 8'h55);
    wr(32'h200, 8'h55);
    rd(32'h200, 1'b0, 32'h0);
    rd(32'h200, 1'b1, 32'h44332255);
    rd(32'h202, 1'b0, 32'h0);

    // Flush, then re-flush at sweep count 40; stores during sweep dropped.
    cyc(1'b1, 32'h200, 8'h66, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 32'h300, 8'hEE, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    cyc(1'b1, 32'h300, 8'hEE, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.write_bit  = 1'b1;
    bus.write_addr = 32'h300;
    bus.write_data = 8'hEE;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.flush_busy_o) begin
        bus.write_bit = 1'b0;
        break;
      end
      n++;
    end
    bus.write_bit = 1'b0;
    check1("reflush_sweep_cycles", n, 32'd128);
    @(posedge clk);
    #1;
    rd(32'h200, 1'b0, 32'h0);
    rd(32'h300, 1'b0, 32'h0);
    wr(32'h301, 8'hBB);
    wr(32'h302, 8'hCC);
    wr(32'h303, 8'hDD);
    idle();
    rd(32'h300, 1'b0, 32'h0);          // byte 0 never survived
    wr(32'h300, 8'hAB);
    idle();
    rd(32'h300, 1'b1, 32'hDDCCBBAB);

`ifdef LOAD_FILL_EN
    fill(32'h400, 8'h01);
    fill(32'h401, 8'h02);
    fill(32'h402, 8'h03);
    fill(32'h403, 8'h04);
    idle();
    rd(32'h400, 1'b1, 32'h04030201);
    fill(32'h405, 8'h05);
    fill(32'h406, 8'h06);
    fill(32'h407, 8'h07);
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = 32'h404;
    bus.fill_data_i  = 8'h08;
    wr(32'h500, 8'h50);
    idle();
    rd(32'h404, 1'b0, 32'h0);          // fill lost to the store
    wr(32'h501, 8'h51);
    wr(32'h502, 8'h52);
    wr(32'h503, 8'h53);
    idle();
    rd(32'h500, 1'b1, 32'h53525150);
`endif

    idle();
    idle();
    check1("scoreboard_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
